// File: rtl/twiddle_pkg.sv
// rtl/twiddle_pkg.sv - quadrant encoding and quarter-wave table derivation for twiddle_gen
package twiddle_pkg;

  typedef enum logic [1:0] {
    QUAD_0 = 2'd0,
    QUAD_1 = 2'd1,
    QUAD_2 = 2'd2,
    QUAD_3 = 2'd3
  } quadrant_e;

  localparam int     FRAC_BITS = 28;
  localparam longint ONE_FX    = 64'sd1 <<< FRAC_BITS;
  localparam longint TWO_PI_FX = 64'sd1686629713;

  function automatic int quarter_len(input int addr_w);
    return 1 << (addr_w - 2);
  endfunction

  function automatic int q_max(input int data_w);
    return (1 << (data_w - 1)) - 1;
  endfunction

  // round(q_max * cos(2*pi*m/N)) from a fixed-point Taylor series, evaluated at elaboration.
  function automatic int quarter_cos(input int m, input int addr_w, input int data_w);
    longint x;
    longint x2;
    longint term;
    longint sum;
    int     result;
    if (m == 0) begin
      result = q_max(data_w);
    end else if (m >= quarter_len(addr_w)) begin
      result = 0;
    end else begin
      x    = (TWO_PI_FX * longint'(m)) >>> addr_w;
      x2   = (x * x) >>> FRAC_BITS;
      term = ONE_FX;
      sum  = ONE_FX;
      for (int n = 1; n <= 10; n++) begin
        term = -(term * x2) / (longint'(2 * n - 1) * longint'(2 * n) * ONE_FX);
        sum  = sum + term;
      end
      result = int'((longint'(q_max(data_w)) * sum + ONE_FX / 2) >>> FRAC_BITS);
    end
    return result;
  endfunction

endpackage

// File: rtl/twiddle_quarter_rom.sv
// rtl/twiddle_quarter_rom.sv - dual-read-port quarter-wave cosine table, N/4+1 entries
module twiddle_quarter_rom
  import twiddle_pkg::*;
#(
  parameter int    ADDR_W = 6,
  parameter int    DATA_W = 8,
  parameter string FILE_Q = "hdl/twiddle_quarter.list"
) (
  input  logic                     clk,
  input  logic                     en,
  input  logic [ADDR_W-1:0]        addr_a,
  input  logic [ADDR_W-1:0]        addr_b,
  output logic signed [DATA_W-1:0] data_a,
  output logic signed [DATA_W-1:0] data_b
);

  localparam int DEPTH = quarter_len(ADDR_W + 1) + 1;

  logic signed [DATA_W-1:0] rom [DEPTH];

  // Contents are fixed at elaboration; FILE_Q names the matching hex image for external tools.
  for (genvar m = 0; m < DEPTH; m++) begin : g_entry
    localparam int QV = quarter_cos(m, ADDR_W + 1, DATA_W);
    assign rom[m] = DATA_W'(QV);
  end

  always_ff @(posedge clk) begin
    if (en) begin
      data_a <= rom[addr_a];
      data_b <= rom[addr_b];
    end
  end

endmodule

// File: rtl/twiddle_gen.sv
// rtl/twiddle_gen.sv - two-stage FFT twiddle generator with phase accumulator and backpressure
module twiddle_gen
  import twiddle_pkg::*;
#(
  parameter int    ADDR_W = 7,
  parameter int    DATA_W = 8,
  parameter string FILE_Q = "hdl/twiddle_quarter.list"
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [ADDR_W-1:0]        in_index,
  input  logic                     in_rel,
  input  logic                     in_inv,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic signed [DATA_W-1:0] out_real,
  output logic signed [DATA_W-1:0] out_imag
);

  localparam int RW      = ADDR_W - 2;
  localparam int QUARTER = quarter_len(ADDR_W);

  logic                     en;
  logic                     accept;
  logic [ADDR_W-1:0]        acc;
  logic [ADDR_W-1:0]        k;
  logic [ADDR_W-2:0]        addr_r;
  logic [ADDR_W-2:0]        addr_rc;
  logic                     s1_valid;
  logic                     s1_inv;
  quadrant_e                s1_quad;
  logic signed [DATA_W-1:0] q_r;
  logic signed [DATA_W-1:0] q_rc;
  logic signed [DATA_W-1:0] c;
  logic signed [DATA_W-1:0] s;

  // One enable stalls the whole pipeline and the accumulator together.
  assign en       = !out_valid || out_ready;
  assign in_ready = en;
  assign accept   = en && in_valid;

  assign k       = in_rel ? acc + in_index : in_index;
  assign addr_r  = {1'b0, k[RW-1:0]};
  assign addr_rc = (ADDR_W - 1)'(QUARTER) - addr_r;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc <= '0;
    end else if (accept) begin
      acc <= k;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid <= 1'b0;
      s1_inv   <= 1'b0;
      s1_quad  <= QUAD_0;
    end else if (en) begin
      s1_valid <= in_valid;
      s1_inv   <= in_inv;
      s1_quad  <= quadrant_e'(k[ADDR_W-1 -: 2]);
    end
  end

  twiddle_quarter_rom #(
    .ADDR_W (ADDR_W - 1),
    .DATA_W (DATA_W),
    .FILE_Q (FILE_Q)
  ) u_rom (
    .clk    (clk),
    .en     (en),
    .addr_a (addr_r),
    .addr_b (addr_rc),
    .data_a (q_r),
    .data_b (q_rc)
  );

  // (c, s) = (cos, sin) of the full-circle angle rebuilt from the first-quadrant pair.
  always_comb begin
    c = q_r;
    s = q_rc;
    case (s1_quad)
      QUAD_0: begin c = q_r;   s = q_rc;  end
      QUAD_1: begin c = -q_rc; s = q_r;   end
      QUAD_2: begin c = -q_r;  s = -q_rc; end
      QUAD_3: begin c = q_rc;  s = -q_r;  end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_real  <= '0;
      out_imag  <= '0;
    end else if (en) begin
      out_valid <= s1_valid;
      out_real  <= c;
      out_imag  <= s1_inv ? s : -s;
    end
  end

endmodule

// File: tb/tb_twiddle_gen.sv
// tb/tb_twiddle_gen.sv - directed self-checking bench for twiddle_gen (N=128, 8-bit)
module tb_twiddle_gen;

  localparam int ADDR_W = 7;
  localparam int DATA_W = 8;

  logic                     clk = 1'b0;
  logic                     rst_n = 1'b0;
  logic                     in_valid = 1'b0;
  logic                     in_rel = 1'b0;
  logic                     in_inv = 1'b0;
  logic                     out_ready = 1'b1;
  logic [ADDR_W-1:0]        in_index = '0;
  logic                     in_ready;
  logic                     out_valid;
  logic signed [DATA_W-1:0] out_real;
  logic signed [DATA_W-1:0] out_imag;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  twiddle_gen #(
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_index  (in_index),
    .in_rel    (in_rel),
    .in_inv    (in_inv),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_real  (out_real),
    .out_imag  (out_imag)
  );

  task automatic chk(input string tag, input logic signed [31:0] obs, input logic signed [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input int k, input bit rel, input bit inv);
    in_valid = 1'b1;
    in_index = ADDR_W'(k);
    in_rel   = rel;
    in_inv   = inv;
  endtask

  task automatic idle();
    in_valid = 1'b0;
    in_rel   = 1'b0;
    in_inv   = 1'b0;
  endtask

  task automatic expect_out(input string tag, input int re, input int im);
    chk({tag, ".valid"}, out_valid, 1);
    chk({tag, ".real"}, out_real, re);
    chk({tag, ".imag"}, out_imag, im);
  endtask

  function automatic int rnd(input real x);
    return $rtoi($floor(x + 0.5));
  endfunction

  task automatic ref_tw(input int k, input bit inv, output int re, output int im);
    real th;
    th = 2.0 * 3.14159265358979323846 * real'(k) / 128.0;
    re = rnd(127.0 * $cos(th));
    im = rnd(-127.0 * $sin(th));
    if (inv) im = -im;
  endtask

  initial begin
    int   re;
    int   im;
    int   got;
    int   next;
    int   held_re;
    int   held_im;
    bit   stall_seen;
    logic fire;
    int   exp_re[$];
    int   exp_im[$];

    // reset state
    idle();
    rst_n = 1'b0;
    repeat (3) tick();
    chk("rst.out_valid", out_valid, 0);
    chk("rst.out_real", out_real, 0);
    chk("rst.out_imag", out_imag, 0);
    chk("rst.acc", dut.acc, 0);
    rst_n = 1'b1;
    #1;
    chk("rst.in_ready", in_ready, 1);
    tick();

    // absolute quadrant sweep
    drive(0, 0, 0);  tick();
    drive(32, 0, 0); tick(); expect_out("sweep0", 127, 0);
    drive(64, 0, 0); tick(); expect_out("sweep32", 0, -127);
    drive(96, 0, 0); tick(); expect_out("sweep64", -127, 0);
    idle();          tick(); expect_out("sweep96", 0, 127);
    tick();
    chk("sweep.drain", out_valid, 0);

    // per-request inverse flag
    drive(16, 0, 0); tick();
    drive(16, 0, 1); tick(); expect_out("k16.fwd", 90, -90);
    idle();          tick(); expect_out("k16.inv", 90, 90);
    tick();
    chk("k16.drain", out_valid, 0);

    // relative stepping with wrap, then a bubble
    drive(125, 0, 0); tick();
    drive(5, 1, 0);   tick(); expect_out("rel.k125", 126, 19);
    drive(0, 1, 0);   tick(); expect_out("rel.k2a", 126, -12);
    idle();           tick(); expect_out("rel.k2b", 126, -12);
    chk("rel.acc", dut.acc, 2);
    tick();
    chk("rel.bubble_valid", out_valid, 0);
    chk("rel.bubble_acc", dut.acc, 2);
    drive(0, 1, 0); tick();
    idle();         tick(); expect_out("rel.after_bubble", 126, -12);
    tick();

    // backpressure: out_ready low for 3 cycles mid-stream
    next = 0;
    got = 0;
    stall_seen = 1'b0;
    held_re = 0;
    held_im = 0;
    for (int cyc = 0; cyc < 40 && got < 10; cyc++) begin
      out_ready = !(cyc >= 5 && cyc < 8);
      in_valid  = (next < 10);
      in_rel    = 1'b0;
      in_inv    = 1'b0;
      in_index  = ADDR_W'(next);
      #1;
      if (!out_ready) begin
        chk("bp.stall_in_ready", in_ready, 0);
        chk("bp.stall_valid", out_valid, 1);
        if (stall_seen) begin
          chk("bp.hold_real", out_real, held_re);
          chk("bp.hold_imag", out_imag, held_im);
        end
        held_re = out_real;
        held_im = out_imag;
        stall_seen = 1'b1;
      end else if (out_valid) begin
        ref_tw(got, 1'b0, re, im);
        chk("bp.real", out_real, re);
        chk("bp.imag", out_imag, im);
        got++;
      end
      fire = in_valid && in_ready;
      tick();
      if (fire) next++;
    end
    chk("bp.count", got, 10);
    chk("bp.stalled", stall_seen, 1);
    out_ready = 1'b1;
    idle();
    tick();
    chk("bp.no_dup", out_valid, 0);

    // reset with two requests in flight
    drive(3, 0, 0); tick();
    drive(5, 0, 0); tick();
    idle();
    chk("rst2.pre_valid", out_valid, 1);
    rst_n = 1'b0;
    #1;
    chk("rst2.out_valid", out_valid, 0);
    chk("rst2.out_real", out_real, 0);
    chk("rst2.out_imag", out_imag, 0);
    chk("rst2.acc", dut.acc, 0);
    tick();
    tick();
    rst_n = 1'b1;
    #1;
    chk("rst2.in_ready", in_ready, 1);
    tick();
    chk("rst2.no_stale_a", out_valid, 0);
    tick();
    chk("rst2.no_stale_b", out_valid, 0);
    drive(8, 0, 0); tick();
    idle();         tick(); expect_out("rst2.k8", 117, -49);
    tick();

    // every index with both inverse settings interleaved
    got = 0;
    for (int i = 0; i < 264; i++) begin
      if (i < 256) begin
        drive(i >> 1, 1'b0, i[0]);
        ref_tw(i >> 1, i[0], re, im);
        exp_re.push_back(re);
        exp_im.push_back(im);
      end else begin
        idle();
      end
      tick();
      if (out_valid) begin
        if (exp_re.size() == 0) begin
          chk("exh.extra", out_valid, 0);
        end else begin
          chk($sformatf("exh.real[%0d]", got), out_real, exp_re.pop_front());
          chk($sformatf("exh.imag[%0d]", got), out_imag, exp_im.pop_front());
          got++;
        end
      end
    end
    chk("exh.count", got, 256);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
